// File: rtl/mixed_opcode_scheduler.sv
// Round-robin scheduler for two opcode-tag requesters sharing one memory command port.
// WAIT tags become a local timed stall; illegal opcode types are consumed and flagged.
module mixed_opcode_scheduler #(
    parameter int unsigned TAG_W     = 9,
    parameter int unsigned IDX_W     = 4,
    parameter bit          ARB_START = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reqA_valid,
    input  logic [TAG_W-1:0]   reqA_tag,
    input  logic [IDX_W-1:0]   reqA_index,
    output logic               reqA_ready,
    input  logic               reqB_valid,
    input  logic [TAG_W-1:0]   reqB_tag,
    input  logic [IDX_W-1:0]   reqB_index,
    output logic               reqB_ready,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [2:0]         mem_opcode,
    output logic [TAG_W-4:0]   mem_arg,
    output logic [IDX_W-1:0]   mem_index,
    output logic               mem_src,
    output logic               busy,
    output logic               err_pulse
);

    localparam int unsigned ArgW = TAG_W - 3;

    localparam logic [2:0] OpRead  = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpWait  = 3'd2;
    localparam logic [2:0] OpEvict = 3'd3;
    localparam logic [2:0] OpTrim  = 3'd4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;       // 1: uBlockB wins a tie
    logic [ArgW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [ArgW-1:0]   arg_q, arg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              src_q, src_d;
    logic              err_q, err_d;

    logic              grant_a, grant_b, idle, hs;
    logic [TAG_W-1:0]  sel_tag;
    logic [IDX_W-1:0]  sel_idx;
    logic [2:0]        sel_type;

    always_comb begin
        idle       = (state_q == StIdle);
        grant_b    = reqB_valid & (~reqA_valid | prio_q);
        grant_a    = reqA_valid & ~grant_b;
        reqA_ready = idle & grant_a;
        reqB_ready = idle & grant_b;
        hs         = reqA_ready | reqB_ready;
        sel_tag    = grant_b ? reqB_tag : reqA_tag;
        sel_idx    = grant_b ? reqB_index : reqA_index;
        sel_type   = sel_tag[TAG_W-1 -: 3];
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        arg_d   = arg_q;
        idx_d   = idx_q;
        src_d   = src_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    op_d   = sel_type;
                    arg_d  = sel_tag[ArgW-1:0];
                    idx_d  = sel_idx;
                    src_d  = grant_b;
                    prio_d = ~grant_b;
                    unique case (sel_type)
                        OpRead, OpWrite, OpEvict, OpTrim: state_d = StIssue;
                        OpWait: begin
                            state_d = StWait;
                            cnt_d   = sel_tag[ArgW-1:0];
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StIssue: begin
                if (mem_ready) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - ArgW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prio_q  <= ARB_START;
            cnt_q   <= '0;
            op_q    <= '0;
            arg_q   <= '0;
            idx_q   <= '0;
            src_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            idx_q   <= idx_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    // mem_valid is decoded from state so it drops with the asynchronous reset
    assign mem_valid  = (state_q == StIssue);
    assign busy       = (state_q != StIdle);
    assign mem_opcode = op_q;
    assign mem_arg    = arg_q;
    assign mem_index  = idx_q;
    assign mem_src    = src_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_mixed_opcode_scheduler.sv
// Directed bench for mixed_opcode_scheduler: per-cycle vector table plus multi-cycle sequences.
module tb_mixed_opcode_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reqA_valid, reqB_valid, mem_ready;
    logic [8:0] reqA_tag, reqB_tag;
    logic [3:0] reqA_index, reqB_index;
    logic       reqA_ready, reqB_ready, mem_valid, mem_src, busy, err_pulse;
    logic [2:0] mem_opcode;
    logic [5:0] mem_arg;
    logic [3:0] mem_index;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mixed_opcode_scheduler #(.TAG_W(9), .IDX_W(4), .ARB_START(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqA_valid (reqA_valid),
        .reqA_tag   (reqA_tag),
        .reqA_index (reqA_index),
        .reqA_ready (reqA_ready),
        .reqB_valid (reqB_valid),
        .reqB_tag   (reqB_tag),
        .reqB_index (reqB_index),
        .reqB_ready (reqB_ready),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_opcode (mem_opcode),
        .mem_arg    (mem_arg),
        .mem_index  (mem_index),
        .mem_src    (mem_src),
        .busy       (busy),
        .err_pulse  (err_pulse)
    );

    typedef struct {
        logic       va; logic [8:0] ta; logic [3:0] ia;
        logic       vb; logic [8:0] tb; logic [3:0] ib;
        logic       mr;
        logic       e_ra, e_rb, e_mv, e_busy, e_err;
        logic       chk_mem;
        logic [2:0] e_op; logic [5:0] e_arg; logic [3:0] e_idx; logic e_src;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_ctl(input string t, input logic ra, input logic rb, input logic mv,
                           input logic bz, input logic er);
        chk({t, ".reqA_ready"}, reqA_ready, ra);
        chk({t, ".reqB_ready"}, reqB_ready, rb);
        chk({t, ".mem_valid"},  mem_valid,  mv);
        chk({t, ".busy"},       busy,       bz);
        chk({t, ".err_pulse"},  err_pulse,  er);
    endtask

    task automatic exp_mem(input string t, input logic [2:0] op, input logic [5:0] arg,
                           input logic [3:0] idx, input logic src);
        chk({t, ".mem_opcode"}, mem_opcode, op);
        chk({t, ".mem_arg"},    mem_arg,    arg);
        chk({t, ".mem_index"},  mem_index,  idx);
        chk({t, ".mem_src"},    mem_src,    src);
    endtask

    task automatic drive(input logic va, input logic [8:0] ta, input logic [3:0] ia,
                         input logic vb, input logic [8:0] tb, input logic [3:0] ib,
                         input logic mr);
        reqA_valid = va; reqA_tag = ta; reqA_index = ia;
        reqB_valid = vb; reqB_tag = tb; reqB_index = ib;
        mem_ready  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // va ta ia  vb tb ib  mr | ra rb mv busy err | chk op arg idx src
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 0, 0, 1, 1, 0, 1, 0, 2, 2, 1});
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 1, 0, 0, 0, 0, 1, 0, 2, 2, 1});
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{1, 9'h045, 4'd3, 0, 9'h000, 4'd0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1, 0, 0, 1, 1, 0, 1, 1, 5, 3, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1, 0, 0, 0, 0, 0, 1, 1, 5, 3, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 1, 9'h1C0, 4'd5, 1, 0, 1, 0, 0, 0, 1, 1, 5, 3, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0});

        rst_n = 1'b0;
        drive(0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].va, vecs[i].ta, vecs[i].ia, vecs[i].vb, vecs[i].tb, vecs[i].ib,
                  vecs[i].mr);
            #1;
            exp_ctl($sformatf("vec%0d", i), vecs[i].e_ra, vecs[i].e_rb, vecs[i].e_mv,
                    vecs[i].e_busy, vecs[i].e_err);
            if (vecs[i].chk_mem)
                exp_mem($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].e_arg, vecs[i].e_idx,
                        vecs[i].e_src);
            tick();
        end

        // WAIT arg 3 from A: four busy cycles, B held off until busy falls
        drive(1, 9'h083, 4'd0, 0, 9'h000, 4'd0, 1);
        #1; exp_ctl("wait_acc", 1, 0, 0, 0, 0);
        tick();
        drive(0, 9'h000, 4'd0, 1, 9'h002, 4'd2, 1);
        for (int i = 0; i < 4; i++) begin
            #1; exp_ctl($sformatf("wait_c%0d", i), 0, 0, 0, 1, 0);
            tick();
        end
        #1; exp_ctl("wait_done", 0, 1, 0, 0, 0);
        tick();
        drive(0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1);
        #1; exp_ctl("wait_b_issue", 0, 0, 1, 1, 0);
        exp_mem("wait_b_issue", 0, 2, 2, 1);
        tick();

        // Backpressure: WRITE held for 10 cycles with mem_ready low
        drive(1, 9'h047, 4'd9, 0, 9'h000, 4'd0, 0);
        #1; exp_ctl("bp_acc", 1, 0, 0, 0, 0);
        tick();
        drive(0, 9'h000, 4'd0, 1, 9'h002, 4'd2, 0);
        for (int i = 0; i < 10; i++) begin
            #1; exp_ctl($sformatf("bp_c%0d", i), 0, 0, 1, 1, 0);
            exp_mem($sformatf("bp_c%0d", i), 1, 7, 9, 0);
            tick();
        end
        drive(0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1);
        #1; exp_ctl("bp_hs", 0, 0, 1, 1, 0);
        tick();
        #1; exp_ctl("bp_idle", 0, 0, 0, 0, 0);
        tick();

        // Reset mid-WAIT, then A must win a tie
        drive(1, 9'h085, 4'd0, 0, 9'h000, 4'd0, 1);
        #1; exp_ctl("rw_acc", 1, 0, 0, 0, 0);
        tick();
        drive(0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1);
        #1; exp_ctl("rw_busy", 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        #1; exp_ctl("rw_rst", 0, 0, 0, 0, 0);
        exp_mem("rw_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1; rst_n = 1'b1;
        drive(1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1);
        #1; exp_ctl("rw_tie", 1, 0, 0, 0, 0);
        tick();

        // Reset mid-ISSUE drops the command, then A wins the tie again
        drive(0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 0);
        #1; exp_ctl("ri_issue", 0, 0, 1, 1, 0);
        exp_mem("ri_issue", 0, 1, 1, 0);
        rst_n = 1'b0;
        #1; exp_ctl("ri_rst", 0, 0, 0, 0, 0);
        exp_mem("ri_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1; rst_n = 1'b1;
        drive(1, 9'h001, 4'd1, 1, 9'h002, 4'd2, 1);
        #1; exp_ctl("ri_tie", 1, 0, 0, 0, 0);
        tick();
        drive(0, 9'h000, 4'd0, 0, 9'h000, 4'd0, 1);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
